// File: rtl/rf_dumper_pkg.sv
// Shared widths and state encoding for the register-file dump sequencer.
package rf_dumper_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/rf_dumper.sv
// Walks every register-file address on one read port and streams (addr, data)
// beats over a valid/ready channel; abortable, single done pulse at the end.
module rf_dumper
  import rf_dumper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;

  // Next-state, counter and beat capture; outputs follow the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          data_d  = rf_rdata;
          addr_d  = cnt_q;
          last_d  = (cnt_q == LAST_ADDR);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // abort wins over a handshake in the same cycle
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (out_ready) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d = ST_READ;
            cnt_d   = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d  = (state_d == ST_READ) || (state_d == ST_SEND);
    valid_d = (state_d == ST_SEND);
    done_d  = (state_d == ST_DONE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rf_raddr  = cnt_q;
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: doc/rf_dumper.md
# rf_dumper

Read-side sequencer for the 32×32 register file: on a start pulse it walks every read address from 0 to 2^ADDR_WIDTH−1 over one register-file read port, captures each word and streams it out as (address, data) beats over a valid/ready handshake. It sits beside the CPU datapath, shares the register file's second read port through a debug mux, and feeds the trace/dump channel to the host interface. Register 0 is not special-cased here; the register file already returns 0 for it.

## Interface
- DATA_WIDTH, 32, register word width
- ADDR_WIDTH, 5, register address width; dump covers 2^ADDR_WIDTH entries
- clk  in  1  rising-edge clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  dump request, sampled only in IDLE
- abort  in  1  cancel a dump in progress
- busy  out  1  high in READ and SEND
- done  out  1  one-cycle pulse after the last beat is accepted
- rf_raddr  out  ADDR_WIDTH  register file read address (file read is combinational)
- rf_rdata  in  DATA_WIDTH  register file read data
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_addr  out  ADDR_WIDTH  register index of the beat
- out_data  out  DATA_WIDTH  register contents
- out_last  out  1  high with the beat for address 2^ADDR_WIDTH−1

## Operation
- States: IDLE, READ, SEND, DONE; encoding is 2-bit binary.
- IDLE: rf_raddr=0. start=1 → READ, address counter=0.
- READ: rf_raddr=counter. Capture rf_rdata into the data register and the counter into out_addr. Go to SEND.
- SEND: out_valid=1. out_addr, out_data and out_last are held stable until the handshake (out_valid & out_ready).
  - On handshake with counter=max → DONE.
  - Otherwise counter+1 → READ.
- DONE: done=1 for exactly one cycle → IDLE.
- Counter is ADDR_WIDTH bits. It never wraps inside a dump, because termination is decided at max.
- start outside IDLE is ignored; a start held high re-triggers only after returning to IDLE.
- abort in READ or SEND → IDLE next cycle. out_valid drops, no done pulse, counter cleared. abort has priority over a simultaneous handshake. abort in IDLE/DONE has no effect.
- Reset mid-dump: all state is cleared immediately (asynchronous). No done pulse.
- Reset values: busy=0, done=0, rf_raddr=0, out_valid=0, out_addr=0, out_data=0, out_last=0, state=IDLE.

## Timing
- Cycle numbering: start sampled at edge 0.
  - Cycle 1: READ, busy=1, rf_raddr=0.
  - Cycle 2: out_valid=1, out_addr=0.
- Throughput is one beat per 2 cycles with out_ready held high; each cycle of out_ready=0 in SEND adds one cycle.
- Full dump with out_ready=1: last beat (addr 31) valid in cycle 64, done=1 in cycle 65, busy=0 from cycle 65, IDLE in cycle 66.
- The earliest re-start is sampled in cycle 66.
- out_data reflects register-file contents at the READ cycle for that address. Writes after that cycle are not reflected.
- All outputs are registered except rf_raddr, which is driven from the counter register.

## Structure
- Shared package/header: DATA_WIDTH and ADDR_WIDTH defines, and the dumper state encoding constants.
- Single module; no sub-module is warranted (FSM + counter + output register).

## Test plan
- Reset, then preload rf[i]=i*0x01010101 and pulse start with out_ready=1 → 32 beats with addr 0..31. Data is 0 for addr 0, then 0x01010101…0x1F1F1F1F. out_last only on addr 31. done in cycle 65.
- Random out_ready (50%) → identical beat sequence. out_addr/out_data are stable while out_valid & !out_ready. Beat count is 32, done is pulsed once.
- abort asserted together with the handshake of addr 10 → no further beats, busy=0 next cycle, no done, next start begins at addr 0.
- start held high for the whole run → exactly one dump, then a second dump beginning with start sampled in cycle 66.
- resetn pulled low while SEND is holding addr 5 → all outputs 0 immediately. After release, the block stays in IDLE until start.
- Register-file write to rf[20]=0xDEADBEEF while the dump is at addr 3 → beat 20 carries 0xDEADBEEF. A write to rf[2] at the same time does not alter the already-sent beat 2.
